// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback over a shared ALU and memory port.
// Optional retired-instruction counter on output instret when PERF_CNT_EN is defined.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       RegWrite,
  output logic [1:0] WBSel,
  output logic [1:0] ALUSrcA,
  output logic       ALUSrc,
  output logic [1:0] ALUOp,
  output logic       illegal,
  output logic [2:0] state_o
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] instret
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BR     = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [7:0] TMO       = 8'(TIMEOUT_CYCLES);

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic       r_taken;
  logic [7:0] r_wd_cnt;

  logic w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr, w_legal;
  logic w_mem_wait, w_wd_hit;

  assign w_is_load   = (opcode == OP_LOAD);
  assign w_is_store  = (opcode == OP_STORE);
  assign w_is_branch = (opcode == OP_BRANCH);
  assign w_is_jal    = (opcode == OP_JAL);
  assign w_is_jalr   = (opcode == OP_JALR);
  assign w_legal     = opcode inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                                      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  // Watchdog fires on the wait cycle that would bring the count up to TMO.
  assign w_mem_wait = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
  assign w_wd_hit   = (TMO != 8'd0) && w_mem_wait && (r_wd_cnt == TMO - 8'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
                else if (w_wd_hit) w_next = S_TRAP;
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC:   if (w_is_load || w_is_store) w_next = S_MEM;
                else if (w_is_branch) w_next = S_BR;
                else w_next = S_WB;
      S_MEM:    if (mem_ready) w_next = w_is_store ? S_FETCH : S_WB;
                else if (w_wd_hit) w_next = S_TRAP;
      S_WB:     w_next = S_FETCH;
      S_BR:     w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
      r_taken   <= 1'b0;
      r_wd_cnt  <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      if ((r_state == S_EXEC) && w_is_branch) r_taken <= branch_taken;
      if ((w_next != r_state) || !w_mem_wait) r_wd_cnt <= 8'd0;
      else r_wd_cnt <= r_wd_cnt + 8'd1;
    end
  end

  // FETCH and MEM handshake strobes are Mealy on mem_ready; everything else decodes the state.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 2'b00;
    RegWrite = 1'b0;
    WBSel    = 2'b00;
    ALUSrcA  = 2'b00;
    ALUSrc   = 1'b0;
    ALUOp    = 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        IRWrite = mem_ready;
      end
      S_EXEC: begin
        case (opcode)
          OP_R:      ALUOp = 2'b10;
          OP_IMM:    begin ALUSrc = 1'b1; ALUOp = 2'b10; end
          OP_BRANCH: ALUOp = 2'b01;
          OP_JAL, OP_AUIPC: begin ALUSrcA = 2'b01; ALUSrc = 1'b1; end
          OP_LUI:    begin ALUSrcA = 2'b10; ALUSrc = 1'b1; end
          default:   ALUSrc = 1'b1;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        mem_we  = w_is_store;
        PCWrite = w_is_store && mem_ready;
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        WBSel    = w_is_load ? 2'b01 : ((w_is_jal || w_is_jalr) ? 2'b10 : 2'b00);
        PCSrc    = w_is_jal ? 2'b01 : (w_is_jalr ? 2'b10 : 2'b00);
      end
      S_BR: begin
        ALUSrcA = 2'b01;
        ALUSrc  = 1'b1;
        PCWrite = 1'b1;
        PCSrc   = r_taken ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

  assign illegal = r_illegal;
  assign state_o = r_state;

`ifdef PERF_CNT_EN
  logic w_retire;
  assign w_retire = (r_state == S_WB) || (r_state == S_BR) ||
                    ((r_state == S_MEM) && w_is_store && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret <= 32'd0;
    else if (w_retire) instret <= instret + 32'd1;
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces built from the opcode rules,
// replayed cycle by cycle with randomized waits and don't-care inputs.
module tb_multicycle_ctrl;

  localparam int TMO = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite, ALUSrc, illegal;
  logic [1:0] PCSrc, WBSel, ALUSrcA, ALUOp;
  logic [2:0] state_o;
`ifdef PERF_CNT_EN
  logic [31:0] instret;
`endif

  multicycle_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .WBSel(WBSel), .ALUSrcA(ALUSrcA), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .illegal(illegal), .state_o(state_o)
`ifdef PERF_CNT_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] outs;
    logic        mr;
    logic        bt;
    logic [6:0]  op;
    logic        ret;
  } step_t;

  step_t q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    step_no = 0;
  int    exp_instret = 0;
  bit    rnd_idle_mr = 1'b0;

  // Packing order: mem_req mem_we IorD IRWrite PCWrite PCSrc RegWrite WBSel ALUSrcA ALUSrc ALUOp illegal
  function automatic logic [15:0] ov(input logic mreq, input logic mwe, input logic iord,
                                     input logic irw, input logic pcw, input logic [1:0] pcs,
                                     input logic rw, input logic [1:0] wbs, input logic [1:0] asa,
                                     input logic asb, input logic [1:0] aop, input logic ill);
    return {mreq, mwe, iord, irw, pcw, pcs, rw, wbs, asa, asb, aop, ill};
  endfunction

  function automatic logic [15:0] obs_outs();
    return {mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc, RegWrite, WBSel,
            ALUSrcA, ALUSrc, ALUOp, illegal};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] ro();
    return 7'($urandom);
  endfunction

  function automatic logic imr();
    return rnd_idle_mr ? 1'($urandom) : 1'b1;
  endfunction

  function automatic void push(input logic [2:0] st, input logic [15:0] outs, input logic mr,
                               input logic bt, input logic [6:0] op, input logic ret);
    step_t s;
    s.st = st; s.outs = outs; s.mr = mr; s.bt = bt; s.op = op; s.ret = ret;
    q.push_back(s);
  endfunction

  // Expected ALU config in EXEC as {ALUSrcA, ALUSrc, ALUOp}
  function automatic logic [4:0] exec_cfg(input logic [6:0] op);
    case (op)
      OP_R:      return {2'b00, 1'b0, 2'b10};
      OP_IMM:    return {2'b00, 1'b1, 2'b10};
      OP_LOAD:   return {2'b00, 1'b1, 2'b00};
      OP_STORE:  return {2'b00, 1'b1, 2'b00};
      OP_BRANCH: return {2'b00, 1'b0, 2'b01};
      OP_JAL:    return {2'b01, 1'b1, 2'b00};
      OP_JALR:   return {2'b00, 1'b1, 2'b00};
      OP_LUI:    return {2'b10, 1'b1, 2'b00};
      OP_AUIPC:  return {2'b01, 1'b1, 2'b00};
      default:   return 5'd0;
    endcase
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  function automatic void gen(input logic [6:0] op, input logic bt, input int fw, input int mw);
    logic [4:0] cfg;
    logic       st;
    logic [1:0] wbs, pcs;
    for (int i = 0; i < fw; i++)
      push(3'd1, ov(1,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b00,0), 1'b0, rb(), ro(), 1'b0);
    push(3'd1, ov(1,0,0,1,0,2'b00,0,2'b00,2'b00,0,2'b00,0), 1'b1, rb(), ro(), 1'b0);
    push(3'd2, 16'd0, imr(), rb(), op, 1'b0);
    if (!legal(op)) begin
      for (int i = 0; i < 4; i++)
        push(3'd7, ov(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b00,1), imr(), rb(), ro(), 1'b0);
      return;
    end
    cfg = exec_cfg(op);
    push(3'd3, ov(0,0,0,0,0,2'b00,0,2'b00,cfg[4:3],cfg[2],cfg[1:0],0), imr(), bt, op, 1'b0);
    if (op == OP_LOAD || op == OP_STORE) begin
      st = (op == OP_STORE);
      for (int i = 0; i < mw; i++)
        push(3'd4, ov(1,st,1,0,0,2'b00,0,2'b00,2'b00,0,2'b00,0), 1'b0, rb(), op, 1'b0);
      push(3'd4, ov(1,st,1,0,st,2'b00,0,2'b00,2'b00,0,2'b00,0), 1'b1, rb(), op, st);
      if (st) return;
    end
    if (op == OP_BRANCH) begin
      push(3'd6, ov(0,0,0,0,1,(bt ? 2'b01 : 2'b00),0,2'b00,2'b01,1,2'b00,0), imr(), rb(), op, 1'b1);
      return;
    end
    wbs = (op == OP_LOAD) ? 2'b01 : ((op == OP_JAL || op == OP_JALR) ? 2'b10 : 2'b00);
    pcs = (op == OP_JAL) ? 2'b01 : ((op == OP_JALR) ? 2'b10 : 2'b00);
    push(3'd5, ov(0,0,0,0,1,pcs,1,wbs,2'b00,0,2'b00,0), imr(), rb(), op, 1'b1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_q(input int n);
    step_t s;
    int    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      s = q.pop_front();
      @(negedge clk);
      mem_ready = s.mr;
      branch_taken = s.bt;
      opcode = s.op;
      #1;
      chk($sformatf("step%0d_state", step_no), 32'(state_o), 32'(s.st));
      chk($sformatf("step%0d_outs", step_no), 32'(obs_outs()), 32'(s.outs));
`ifdef PERF_CNT_EN
      chk($sformatf("step%0d_instret", step_no), instret, 32'(exp_instret));
`endif
      if (s.ret) exp_instret++;
      step_no++;
      k++;
    end
  endtask

  // Assert reset now, check the cleared state, release after a clock edge and queue the IDLE cycle.
  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    mem_ready = rb();
    #1;
    chk({tag, "_state"}, 32'(state_o), 32'd0);
    chk({tag, "_outs"}, 32'(obs_outs()), 32'd0);
`ifdef PERF_CNT_EN
    chk({tag, "_instret"}, instret, 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete();
    exp_instret = 0;
    push(3'd0, 16'd0, imr(), rb(), ro(), 1'b0);
  endtask

  initial begin
    // Directed instruction set walk with mem_ready idle at 1
    @(negedge clk);
    reset_now("rst0");
    gen(OP_R, 1'b0, 0, 0);
    gen(OP_IMM, 1'b0, 0, 0);
    gen(OP_LOAD, 1'b0, 0, 3);
    gen(OP_STORE, 1'b0, 0, 0);
    gen(OP_BRANCH, 1'b1, 0, 0);
    gen(OP_BRANCH, 1'b0, 0, 0);
    gen(OP_JALR, 1'b0, 0, 0);
    gen(OP_JAL, 1'b0, 1, 0);
    gen(OP_LUI, 1'b0, 0, 0);
    gen(OP_AUIPC, 1'b0, 2, 0);
    gen(OP_BAD, 1'b0, 0, 0);
    run_q(-1);

    // Fetch watchdog: four unanswered fetch cycles then TRAP
    @(negedge clk);
    reset_now("rst1");
    for (int i = 0; i < TMO; i++)
      push(3'd1, ov(1,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b00,0), 1'b0, rb(), ro(), 1'b0);
    for (int i = 0; i < 3; i++)
      push(3'd7, ov(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b00,1), 1'b1, rb(), ro(), 1'b0);
    run_q(-1);

    // Asynchronous reset while waiting in MEM
    @(negedge clk);
    reset_now("rst2");
    gen(OP_LOAD, 1'b0, 0, 3);
    run_q(5);
    #2;
    reset_now("rst_midmem");

    // Three retirements, then randomized traffic with don't-care inputs toggling
    rnd_idle_mr = 1'b1;
    gen(OP_R, 1'b0, 0, 0);
    gen(OP_STORE, 1'b0, 1, 1);
    gen(OP_BRANCH, 1'b1, 0, 0);
    run_q(-1);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 8))
        0: gen(OP_R,      rb(), $urandom_range(0, 3), 0);
        1: gen(OP_IMM,    rb(), $urandom_range(0, 3), 0);
        2: gen(OP_LOAD,   rb(), $urandom_range(0, 3), $urandom_range(0, 3));
        3: gen(OP_STORE,  rb(), $urandom_range(0, 3), $urandom_range(0, 3));
        4: gen(OP_BRANCH, rb(), $urandom_range(0, 3), 0);
        5: gen(OP_JAL,    rb(), $urandom_range(0, 3), 0);
        6: gen(OP_JALR,   rb(), $urandom_range(0, 3), 0);
        7: gen(OP_LUI,    rb(), $urandom_range(0, 3), 0);
        default: gen(OP_AUIPC, rb(), $urandom_range(0, 3), 0);
      endcase
      run_q(-1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy control FSM sequencing the RV32I datapath over multiple cycles. Drives the ALU operand selects (ALUSrcA, and ALUSrc for the rs2/imm operand-B mux), ALUOp, memory handshake, IR/PC/register-file write enables and writeback select.
- Sits between instruction decode (opcode from IR) and the shared ALU/memory datapath. Exactly one instruction is in flight.

Parameters:
- TIMEOUT_CYCLES, 255: maximum wait cycles for mem_ready in FETCH/MEM before TRAP; 0 disables the watchdog. Counter is 8 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction[6:0] from IR, valid from DECODE onward
- branch_taken  in  1  datapath comparator result, sampled at end of EXEC
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = store, 0 = read
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  latch fetched instruction
- PCWrite  out  1  update PC
- PCSrc  out  2  00 = PC+4, 01 = ALUOut, 10 = ALUOut & ~1
- RegWrite  out  1  register-file write enable
- WBSel  out  2  00 = ALUOut, 01 = memory data, 10 = PC+4
- ALUSrcA  out  2  00 = rs1, 01 = PC, 10 = zero
- ALUSrc  out  1  operand B: 0 = rs2, 1 = imm
- ALUOp  out  2  00 = add, 01 = branch compare, 10 = funct3/funct7 decode
- illegal  out  1  sticky illegal-opcode/timeout flag
- state_o  out  3  current state encoding

Behaviour:
- State register is 3 bits: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, BR=6, TRAP=7.
- rst_n low forces state=IDLE asynchronously and clears illegal, taken_q and the watchdog counter. All outputs are 0 in IDLE. Any outstanding mem_req is dropped.
- Outputs not listed for a state are 0.
- IDLE: for one cycle, then go to FETCH.
- FETCH:
  - Drive mem_req=1, IorD=0.
  - Wait for mem_ready. In the cycle mem_ready=1, IRWrite=1 (Mealy), then go to DECODE.
  - mem_ready in the first FETCH cycle is accepted (zero-wait).
- DECODE: one cycle.
  - Unknown opcode goes to TRAP.
  - Otherwise go to EXEC.
- EXEC: one cycle. ALU settings by opcode (ALUSrcA / ALUSrc / ALUOp), then next state:
  - R 0110011: rs1 / 0 / 10, then WB.
  - OP-IMM 0010011: rs1 / 1 / 10, then WB.
  - LOAD 0000011 and STORE 0100011: rs1 / 1 / 00, then MEM.
  - BRANCH 1100011: rs1 / 0 / 01. branch_taken is registered into taken_q. Then BR.
  - JAL 1101111: PC / 1 / 00, then WB.
  - JALR 1100111: rs1 / 1 / 00, then WB.
  - LUI 0110111: zero / 1 / 00, then WB.
  - AUIPC 0010111: PC / 1 / 00, then WB.
- MEM:
  - Drive mem_req=1, IorD=1, mem_we=1 for STORE.
  - Wait for mem_ready.
  - LOAD: go to WB.
  - STORE: in the ready cycle PCWrite=1, PCSrc=00, then FETCH.
- WB: one cycle.
  - RegWrite=1 and PCWrite=1.
  - WBSel: LOAD=01, JAL/JALR=10, others=00.
  - PCSrc: JAL=01, JALR=10, others=00.
  - Then FETCH.
- BR: one cycle.
  - ALUSrcA=PC, ALUSrc=1, ALUOp=00 (target = PC+imm). PCWrite=1.
  - PCSrc=01 if taken_q, else 00.
  - Then FETCH.
- TRAP: absorbing state until reset. All outputs 0, illegal=1.
- Watchdog:
  - Counts consecutive FETCH/MEM cycles with mem_ready=0.
  - Cleared on mem_ready or state change.
  - When the count reaches TIMEOUT_CYCLES (non-zero), go to TRAP next cycle.
- mem_ready outside FETCH/MEM is ignored.
- Cycle counts with zero-wait memory: R/I/LUI/AUIPC/JAL/JALR 4, LOAD 5, STORE 4, BRANCH 4.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined: adds output instret (32 bits), reset to 0. It increments by 1 on each instruction retirement: the WB cycle, the BR cycle, or the STORE MEM ready cycle. It wraps 0xFFFFFFFF to 0 and does not count in TRAP.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then release with mem_ready=1 constant, then the R-type opcode 0110011 -> state_o sequence 0,1,2,3,5,1. In EXEC, ALUSrc=0, ALUSrcA=00, ALUOp=10. In WB, RegWrite=1, PCWrite=1, PCSrc=00.
- OP-IMM 0010011 -> EXEC has ALUSrc=1. LOAD 0000011 with mem_ready delayed 3 cycles -> MEM holds mem_req=1, IorD=1 for 4 cycles, then WB with WBSel=01.
- STORE 0100011 -> MEM has mem_we=1. The ready cycle has PCWrite=1. RegWrite is never 1. Return to FETCH after 4 total cycles.
- BRANCH with branch_taken=1 -> BR has PCSrc=01. Repeat with branch_taken=0 -> PCSrc=00. In both cases EXEC has ALUSrc=0, ALUOp=01.
- JALR 1100111 -> WB has WBSel=10, PCSrc=10. Illegal opcode 1111111 -> TRAP (state_o=7), illegal=1, all other outputs 0 until rst_n pulse.
- TIMEOUT_CYCLES=4 with mem_ready held 0 in FETCH -> TRAP after 4 wait cycles. rst_n asserted mid-MEM -> immediate IDLE with mem_req=0. With PERF_CNT_EN, after 3 retired instructions instret=3.
